id_ex_pipe_reg: RTL
===================

Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS core.
- Captures the decoder's control bundle plus ID-stage operands, register numbers and immediate each cycle, and presents them to the EX stage.
- Contains the load-use hazard detector. It inserts one bubble into EX and raises a stall to the PC and IF/ID register.
- Supports flush on taken branch or jump, and a global hold.

Parameters:
- DATA_W, 32, width of operand, immediate and PC+4 fields.
- REG_W, 5, register-number width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- hold_i  in  1  global freeze; register keeps its contents.
- flush_i  in  1  taken branch or jump; squash the instruction entering EX.
- RegDst_i, ALUSrc_i, MemtoReg_i, RegWr_i, MemWr_i, MemRd_i  in  1 each  decoder control bits.
- ALUOp_i  in  2  decoder ALU class.
- pc4_i  in  DATA_W  PC+4 of the ID instruction.
- rs_data_i, rt_data_i  in  DATA_W  register-file read data.
- imm_i  in  DATA_W  sign-extended immediate.
- rs_i, rt_i, rd_i  in  REG_W  ID register numbers.
- RegDst_o, ALUSrc_o, MemtoReg_o, RegWr_o, MemWr_o, MemRd_o  out  1 each  registered control bits.
- ALUOp_o  out  2  registered ALU class.
- pc4_o, rs_data_o, rt_data_o, imm_o  out  DATA_W  registered data.
- rs_o, rt_o, rd_o  out  REG_W  registered register numbers.
- valid_o  out  1  EX slot holds a real instruction (0 = bubble).
- hazard_o  out  1  combinational; stall PC and IF/ID this cycle.

Behaviour:
- Reset (rst_i=0, asynchronous): every registered output goes to 0, including valid_o. Reset has priority over all other inputs at any time, including mid-hold or mid-bubble.
- Hazard detection, combinational:
  - hazard_o = MemRd_o & valid_o & (rt_o != 0) & ((rt_o == rs_i) | (rt_o == rt_i)) & !flush_i & !hold_i.
  - No other logic may affect it.
- Update priority at each rising clk_i edge, with reset released:
  1. hold_i=1: all registers keep their values; hazard_o is forced 0.
  2. flush_i=1: load a bubble.
  3. hazard_o=1: load a bubble.
  4. Otherwise: capture every input; valid_o <= 1.
- Bubble definition:
  - All control outputs and valid_o are set to 0; ALUOp_o <= 2'b00.
  - Data and register-number fields are also cleared to 0, so no stale rt_o can retrigger a hazard.
- Latency: exactly one cycle from ID inputs to EX outputs. No combinational path from any input to any registered output.
- Stall duration:
  - A load-use pair produces exactly one bubble.
  - On the following cycle the bubble makes valid_o=0, so hazard_o drops. The held ID instruction is then captured.
- Back-to-back loads with dependency: each dependent consumer gets its own single bubble.
- Flush together with a hazard: flush wins; a bubble is loaded and hazard_o=0, so IF/ID is not stalled and it accepts the branch target.
- Hold together with flush: hold wins. The flush must be reasserted by the requester after the hold is released.
- Register $0 never causes a hazard.
- A sw in EX (MemRd_o=0) never causes a hazard.

Test Plan:
- Reset: assert rst_i=0 mid-cycle with valid contents → all outputs 0 immediately, before the next edge; valid_o=0, hazard_o=0.
- Pass-through: addi, with RegWr_i=1, ALUSrc_i=1, ALUOp_i=01, rt_i=8, imm_i=0x00000005 → one edge later RegWr_o=1, ALUSrc_o=1, ALUOp_o=01, rt_o=8, imm_o=5, valid_o=1.
- Load-use: lw with rt=9 in EX, next ID has rs_i=9 → hazard_o=1 for exactly one cycle. The following edge loads a bubble (all controls 0, valid_o=0). The edge after that captures the consumer with rs_o=9.
- $0 and sw: lw with rt=0 in EX and ID rs_i=0 → hazard_o=0. sw in EX with rt_o=9 and ID rs_i=9 → hazard_o=0.
- Flush priority: lw with rt=9 in EX, ID rs_i=9, flush_i=1 → hazard_o=0; next edge gives a bubble with valid_o=0, MemWr_o=0, RegWr_o=0.
- Hold: hold_i=1 for 3 cycles with changing inputs → outputs unchanged and hazard_o=0 throughout. Release → inputs captured on the next edge.

Source files
------------

// File: rtl/id_ex_pipe_reg_if.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg_if
// Bundle of every signal exchanged between the ID stage, the ID/EX pipeline
// register and the EX stage of the 5-stage MIPS core.
//
//   master : ID/EX side that supplies the decoder bundle and pipeline
//            controls, and observes the registered EX-stage fields and the
//            hazard stall.
//   slave  : the ID/EX register itself (consumes ID fields, drives EX fields).
//
// Signals
//   hold_i, flush_i                      pipeline controls
//   RegDst_i..MemRd_i, ALUOp_i           decoder control bits
//   pc4_i, rs_data_i, rt_data_i, imm_i   ID-stage data (DATA_W)
//   rs_i, rt_i, rd_i                     ID-stage register numbers (REG_W)
//   *_o                                  registered copies for EX
//   valid_o                              EX slot holds a real instruction
//   hazard_o                             combinational load-use stall
// ---------------------------------------------------------------------------
interface id_ex_pipe_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    // Pipeline controls
    logic              hold_i;
    logic              flush_i;

    // ID-stage inputs
    logic              RegDst_i;
    logic              ALUSrc_i;
    logic              MemtoReg_i;
    logic              RegWr_i;
    logic              MemWr_i;
    logic              MemRd_i;
    logic [1:0]        ALUOp_i;
    logic [DATA_W-1:0] pc4_i;
    logic [DATA_W-1:0] rs_data_i;
    logic [DATA_W-1:0] rt_data_i;
    logic [DATA_W-1:0] imm_i;
    logic [REG_W-1:0]  rs_i;
    logic [REG_W-1:0]  rt_i;
    logic [REG_W-1:0]  rd_i;

    // EX-stage outputs
    logic              RegDst_o;
    logic              ALUSrc_o;
    logic              MemtoReg_o;
    logic              RegWr_o;
    logic              MemWr_o;
    logic              MemRd_o;
    logic [1:0]        ALUOp_o;
    logic [DATA_W-1:0] pc4_o;
    logic [DATA_W-1:0] rs_data_o;
    logic [DATA_W-1:0] rt_data_o;
    logic [DATA_W-1:0] imm_o;
    logic [REG_W-1:0]  rs_o;
    logic [REG_W-1:0]  rt_o;
    logic [REG_W-1:0]  rd_o;
    logic              valid_o;
    logic              hazard_o;

    modport master (
        output hold_i, flush_i,
        output RegDst_i, ALUSrc_i, MemtoReg_i, RegWr_i, MemWr_i, MemRd_i,
        output ALUOp_i, pc4_i, rs_data_i, rt_data_i, imm_i, rs_i, rt_i, rd_i,
        input  RegDst_o, ALUSrc_o, MemtoReg_o, RegWr_o, MemWr_o, MemRd_o,
        input  ALUOp_o, pc4_o, rs_data_o, rt_data_o, imm_o, rs_o, rt_o, rd_o,
        input  valid_o, hazard_o
    );

    modport slave (
        input  hold_i, flush_i,
        input  RegDst_i, ALUSrc_i, MemtoReg_i, RegWr_i, MemWr_i, MemRd_i,
        input  ALUOp_i, pc4_i, rs_data_i, rt_data_i, imm_i, rs_i, rt_i, rd_i,
        output RegDst_o, ALUSrc_o, MemtoReg_o, RegWr_o, MemWr_o, MemRd_o,
        output ALUOp_o, pc4_o, rs_data_o, rt_data_o, imm_o, rs_o, rt_o, rd_o,
        output valid_o, hazard_o
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg
// ID/EX pipeline register of the 5-stage MIPS core with the load-use hazard
// detector.  Each rising edge it either keeps its contents (hold), loads a
// bubble (flush or load-use hazard) or captures the ID-stage bundle.
//
// Ports
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous, active-low reset; clears every registered field
//   bus    : id_ex_pipe_reg_if.slave -- ID inputs, EX outputs, hold/flush,
//            valid_o and the combinational hazard_o stall request
// ---------------------------------------------------------------------------
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    id_ex_pipe_reg_if.slave        bus
);

    // Registered EX-stage fields
    logic              r_RegDst;
    logic              r_ALUSrc;
    logic              r_MemtoReg;
    logic              r_RegWr;
    logic              r_MemWr;
    logic              r_MemRd;
    logic [1:0]        r_ALUOp;
    logic [DATA_W-1:0] r_pc4;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic [REG_W-1:0]  r_rs;
    logic [REG_W-1:0]  r_rt;
    logic [REG_W-1:0]  r_rd;
    logic              r_valid;

    logic              w_rt_nonzero;
    logic              w_rt_match;
    logic              w_hazard;
    logic              w_bubble;

    // Load-use detection looks only at the load sitting in EX and the
    // register numbers currently in ID.  Flush and hold both mask it:
    // under flush the ID instruction is being discarded anyway, and under
    // hold nothing moves so a stall request would be meaningless.
    assign w_rt_nonzero = (r_rt != '0);
    assign w_rt_match   = (r_rt == bus.rs_i) | (r_rt == bus.rt_i);
    assign w_hazard     = r_MemRd & r_valid & w_rt_nonzero & w_rt_match
                          & ~bus.flush_i & ~bus.hold_i;

    // A bubble is loaded for a flush or a hazard.  The hazard itself turns
    // off once the bubble lands (valid drops, rt clears), which limits the
    // stall to a single cycle.
    assign w_bubble = bus.flush_i | w_hazard;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_RegDst   <= 1'b0;
            r_ALUSrc   <= 1'b0;
            r_MemtoReg <= 1'b0;
            r_RegWr    <= 1'b0;
            r_MemWr    <= 1'b0;
            r_MemRd    <= 1'b0;
            r_ALUOp    <= 2'b00;
            r_pc4      <= '0;
            r_rs_data  <= '0;
            r_rt_data  <= '0;
            r_imm      <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rd       <= '0;
            r_valid    <= 1'b0;
        end else if (bus.hold_i) begin
            // Freeze: every register keeps its value.
            r_RegDst   <= r_RegDst;
            r_ALUSrc   <= r_ALUSrc;
            r_MemtoReg <= r_MemtoReg;
            r_RegWr    <= r_RegWr;
            r_MemWr    <= r_MemWr;
            r_MemRd    <= r_MemRd;
            r_ALUOp    <= r_ALUOp;
            r_pc4      <= r_pc4;
            r_rs_data  <= r_rs_data;
            r_rt_data  <= r_rt_data;
            r_imm      <= r_imm;
            r_rs       <= r_rs;
            r_rt       <= r_rt;
            r_rd       <= r_rd;
            r_valid    <= r_valid;
        end else if (w_bubble) begin
            // Bubble clears data and register numbers too, so a stale rt
            // cannot re-trigger the hazard detector.
            r_RegDst   <= 1'b0;
            r_ALUSrc   <= 1'b0;
            r_MemtoReg <= 1'b0;
            r_RegWr    <= 1'b0;
            r_MemWr    <= 1'b0;
            r_MemRd    <= 1'b0;
            r_ALUOp    <= 2'b00;
            r_pc4      <= '0;
            r_rs_data  <= '0;
            r_rt_data  <= '0;
            r_imm      <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rd       <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_RegDst   <= bus.RegDst_i;
            r_ALUSrc   <= bus.ALUSrc_i;
            r_MemtoReg <= bus.MemtoReg_i;
            r_RegWr    <= bus.RegWr_i;
            r_MemWr    <= bus.MemWr_i;
            r_MemRd    <= bus.MemRd_i;
            r_ALUOp    <= bus.ALUOp_i;
            r_pc4      <= bus.pc4_i;
            r_rs_data  <= bus.rs_data_i;
            r_rt_data  <= bus.rt_data_i;
            r_imm      <= bus.imm_i;
            r_rs       <= bus.rs_i;
            r_rt       <= bus.rt_i;
            r_rd       <= bus.rd_i;
            r_valid    <= 1'b1;
        end
    end

    // EX-stage outputs come straight from registers.
    assign bus.RegDst_o   = r_RegDst;
    assign bus.ALUSrc_o   = r_ALUSrc;
    assign bus.MemtoReg_o = r_MemtoReg;
    assign bus.RegWr_o    = r_RegWr;
    assign bus.MemWr_o    = r_MemWr;
    assign bus.MemRd_o    = r_MemRd;
    assign bus.ALUOp_o    = r_ALUOp;
    assign bus.pc4_o      = r_pc4;
    assign bus.rs_data_o  = r_rs_data;
    assign bus.rt_data_o  = r_rt_data;
    assign bus.imm_o      = r_imm;
    assign bus.rs_o       = r_rs;
    assign bus.rt_o       = r_rt;
    assign bus.rd_o       = r_rd;
    assign bus.valid_o    = r_valid;
    assign bus.hazard_o   = w_hazard;

endmodule
